// File: rtl/tlb_pkg.sv
// Shared constants, FSM encoding and the permission helper for the TLB.
package tlb_pkg;

  localparam int VA_W  = 32;
  localparam int OFF_W = 12;
  localparam int PPN_W = 20;
  localparam int VPN_W = VA_W - OFF_W;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;

  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_PTW_REQ,
    ST_PTW_WAIT,
    ST_RESP
  } state_e;

  function automatic logic perm_fault(input logic acc, input logic r, input logic w);
    return ((acc == ACC_READ) && !r) || ((acc == ACC_WRITE) && !w);
  endfunction

endpackage

// File: rtl/tlb_if.sv
// CPU request/response and page-table-walker channels of the TLB.
// Every channel is valid/ready: a transfer happens on a clock edge where both are high,
// and the sender keeps valid and its payload stable until that edge.
interface tlb_if;
  import tlb_pkg::*;

  logic            req_valid_i;
  logic            req_ready_o;
  logic [VA_W-1:0] vaddr_i;
  logic            access_type_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [VA_W-1:0] paddr_o;
  logic            hit_o;
  logic            fault_o;
  logic            ptw_req_valid_o;
  logic            ptw_req_ready_i;
  logic [VA_W-1:0] ptw_vaddr_o;
  logic            ptw_resp_valid_i;
  logic            ptw_resp_ready_o;
  logic [31:0]     ptw_pte_i;

  modport slave (
    input  req_valid_i, vaddr_i, access_type_i, resp_ready_i,
           ptw_req_ready_i, ptw_resp_valid_i, ptw_pte_i,
    output req_ready_o, resp_valid_o, paddr_o, hit_o, fault_o,
           ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o
  );

  modport master (
    output req_valid_i, vaddr_i, access_type_i, resp_ready_i,
           ptw_req_ready_i, ptw_resp_valid_i, ptw_pte_i,
    input  req_ready_o, resp_valid_o, paddr_o, hit_o, fault_o,
           ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o
  );

endinterface

// File: rtl/tlb_lru.sv
// True-LRU age tracker for one set: age all-ones is MRU, age zero is LRU.
// Victim is the lowest invalid way, otherwise the way whose age is zero.
module tlb_lru #(
  parameter int NUM_WAYS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_touch_en,
  input  logic [$clog2(NUM_WAYS)-1:0] i_touch_way,
  input  logic [NUM_WAYS-1:0]         i_valid_mask,
  output logic [$clog2(NUM_WAYS)-1:0] o_victim
);

  localparam int WAY_W = $clog2(NUM_WAYS);

  logic [WAY_W-1:0] r_age [NUM_WAYS];
  logic             w_all_valid;

  // Ways fill in index order, so valid ways always hold distinct ages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_WAYS; v++) r_age[v] <= '0;
    end else if (i_touch_en) begin
      for (int v = 0; v < NUM_WAYS; v++) begin
        if (WAY_W'(v) == i_touch_way) begin
          r_age[v] <= '1;
        end else if (r_age[v] > r_age[i_touch_way]) begin
          r_age[v] <= r_age[v] - WAY_W'(1);
        end
      end
    end
  end

  assign w_all_valid = &i_valid_mask;

  always_comb begin
    o_victim = '0;
    for (int v = NUM_WAYS - 1; v >= 0; v--) begin
      if (w_all_valid ? (r_age[v] == '0) : !i_valid_mask[v]) o_victim = WAY_W'(v);
    end
  end

endmodule

// File: rtl/tlb.sv
// Set-associative TLB with LRU refill from a page-table walker.
// Define TLB_PERF_CNT_EN to add saturating hit/miss counter outputs.
module tlb
  import tlb_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  tlb_if.slave   bus,
  output state_e dbg_state_o
`ifdef TLB_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = VPN_W - IDX_W;

  state_e              r_state, w_next;
  logic [VA_W-1:0]     r_vaddr;
  logic                r_acc;
  logic [VA_W-1:0]     r_paddr;
  logic                r_hit, r_fault;

  logic [NUM_WAYS-1:0] r_valid  [NUM_SETS];
  logic [TAG_W-1:0]    r_tag    [NUM_SETS][NUM_WAYS];
  logic [PPN_W-1:0]    r_ppn    [NUM_SETS][NUM_WAYS];
  logic                r_perm_r [NUM_SETS][NUM_WAYS];
  logic                r_perm_w [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [OFF_W-1:0]    w_off;
  logic                w_hit_any, w_hit_r, w_hit_w;
  logic [WAY_W-1:0]    w_hit_way;
  logic [PPN_W-1:0]    w_hit_ppn;
  logic [WAY_W-1:0]    w_victim_set [NUM_SETS];
  logic [WAY_W-1:0]    w_victim;

  logic                w_req_ready, w_resp_valid, w_ptw_req_valid, w_ptw_resp_ready;
  logic                w_touch_en, w_install, w_load_resp;
  logic [WAY_W-1:0]    w_touch_way;
  logic [VA_W-1:0]     w_resp_paddr;
  logic                w_resp_hit, w_resp_fault;
  logic [PPN_W-1:0]    w_pte_ppn;
  logic                w_unused_pte;

  assign w_idx        = r_vaddr[OFF_W +: IDX_W];
  assign w_tag        = r_vaddr[VA_W-1 -: TAG_W];
  assign w_off        = r_vaddr[OFF_W-1:0];
  assign w_pte_ppn    = bus.ptw_pte_i[31 -: PPN_W];
  assign w_unused_pte = ^bus.ptw_pte_i[OFF_W-1:PTE_X];

  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    w_hit_ppn = '0;
    w_hit_r   = 1'b0;
    w_hit_w   = 1'b0;
    for (int v = 0; v < NUM_WAYS; v++) begin
      if (r_valid[w_idx][v] && (r_tag[w_idx][v] == w_tag)) begin
        w_hit_any = 1'b1;
        w_hit_way = WAY_W'(v);
        w_hit_ppn = r_ppn[w_idx][v];
        w_hit_r   = r_perm_r[w_idx][v];
        w_hit_w   = r_perm_w[w_idx][v];
      end
    end
  end

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_lru
    tlb_lru #(.NUM_WAYS(NUM_WAYS)) u_lru (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_touch_en   (w_touch_en && (w_idx == IDX_W'(s))),
      .i_touch_way  (w_touch_way),
      .i_valid_mask (r_valid[s]),
      .o_victim     (w_victim_set[s])
    );
  end

  assign w_victim = w_victim_set[w_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    w_req_ready      = 1'b0;
    w_resp_valid     = 1'b0;
    w_ptw_req_valid  = 1'b0;
    w_ptw_resp_ready = 1'b0;
    w_touch_en       = 1'b0;
    w_touch_way      = w_hit_way;
    w_install        = 1'b0;
    w_load_resp      = 1'b0;
    w_resp_paddr     = '0;
    w_resp_hit       = 1'b0;
    w_resp_fault     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid_i) w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (w_hit_any) begin
          w_next       = ST_RESP;
          w_touch_en   = 1'b1;
          w_load_resp  = 1'b1;
          w_resp_hit   = 1'b1;
          w_resp_fault = perm_fault(r_acc, w_hit_r, w_hit_w);
          w_resp_paddr = w_resp_fault ? '0 : {w_hit_ppn, w_off};
        end else begin
          w_next = ST_PTW_REQ;
        end
      end
      ST_PTW_REQ: begin
        w_ptw_req_valid = 1'b1;
        if (bus.ptw_req_ready_i) w_next = ST_PTW_WAIT;
      end
      ST_PTW_WAIT: begin
        w_ptw_resp_ready = 1'b1;
        if (bus.ptw_resp_valid_i) begin
          w_next      = ST_RESP;
          w_load_resp = 1'b1;
          // Invalid PTEs are reported but never cached, so the next access walks again.
          if (bus.ptw_pte_i[PTE_V]) begin
            w_install    = 1'b1;
            w_touch_en   = 1'b1;
            w_touch_way  = w_victim;
            w_resp_hit   = 1'b1;
            w_resp_fault = perm_fault(r_acc, bus.ptw_pte_i[PTE_R], bus.ptw_pte_i[PTE_W]);
            w_resp_paddr = w_resp_fault ? '0 : {w_pte_ppn, w_off};
          end else begin
            w_resp_fault = 1'b1;
          end
        end
      end
      ST_RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vaddr <= '0;
      r_acc   <= ACC_READ;
      r_paddr <= '0;
      r_hit   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      if (w_req_ready && bus.req_valid_i) begin
        r_vaddr <= bus.vaddr_i;
        r_acc   <= bus.access_type_i;
      end
      if (w_load_resp) begin
        r_paddr <= w_resp_paddr;
        r_hit   <= w_resp_hit;
        r_fault <= w_resp_fault;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) r_valid[s] <= '0;
    end else if (w_install) begin
      r_valid[w_idx][w_victim] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_install) begin
      r_tag[w_idx][w_victim]    <= w_tag;
      r_ppn[w_idx][w_victim]    <= w_pte_ppn;
      r_perm_r[w_idx][w_victim] <= bus.ptw_pte_i[PTE_R];
      r_perm_w[w_idx][w_victim] <= bus.ptw_pte_i[PTE_W];
    end
  end

  assign bus.req_ready_o      = w_req_ready;
  assign bus.resp_valid_o     = w_resp_valid;
  assign bus.paddr_o          = w_resp_valid ? r_paddr : '0;
  assign bus.hit_o            = w_resp_valid & r_hit;
  assign bus.fault_o          = w_resp_valid & r_fault;
  assign bus.ptw_req_valid_o  = w_ptw_req_valid;
  assign bus.ptw_vaddr_o      = w_ptw_req_valid ? r_vaddr : '0;
  assign bus.ptw_resp_ready_o = w_ptw_resp_ready;
  assign dbg_state_o          = r_state;

`ifdef TLB_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == ST_LOOKUP) begin
      if (w_hit_any) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_tlb.sv
// Bench for tlb: directed scenarios plus randomized accesses against a recency-list model.
module tb_tlb;
  import tlb_pkg::*;

  localparam int TB_SETS = 16;
  localparam int TB_WAYS = 4;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;
  always #5 clk = ~clk;

  tlb_if bus();

`ifdef TLB_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  tlb #(.NUM_SETS(TB_SETS), .NUM_WAYS(TB_WAYS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
`ifdef TLB_PERF_CNT_EN
    ,
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;
  int m_hits = 0;
  int m_misses = 0;

  // Model: per set, entries ordered most-recent first.
  logic [19:0] m_vpn [TB_SETS][TB_WAYS];
  logic [31:0] m_pte [TB_SETS][TB_WAYS];
  int          m_cnt [TB_SETS];
  logic [31:0] pt [logic [19:0]];
  logic [33:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    tests++;
    fails++;
    $display("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic m_reset();
    for (int s = 0; s < TB_SETS; s++) m_cnt[s] = 0;
    m_hits = 0;
    m_misses = 0;
  endtask

  function automatic int m_find(input logic [19:0] vpn);
    int s;
    s = int'(vpn % TB_SETS);
    for (int i = 0; i < m_cnt[s]; i++) if (m_vpn[s][i] == vpn) return i;
    return -1;
  endfunction

  task automatic m_front(input int s, input int pos, input logic [19:0] vpn, input logic [31:0] pte);
    for (int i = pos; i > 0; i--) begin
      m_vpn[s][i] = m_vpn[s][i-1];
      m_pte[s][i] = m_pte[s][i-1];
    end
    m_vpn[s][0] = vpn;
    m_pte[s][0] = pte;
  endtask

  task automatic access(input logic [31:0] va, input logic acc);
    logic [19:0] vpn;
    logic [31:0] pte, rnd;
    logic [33:0] exp_v, got;
    logic        exp_miss, pte_sent, f;
    int          s, pos, lat, ptw_seen, extra;
    vpn = va[31:12];
    s = int'(vpn % TB_SETS);
    pos = m_find(vpn);
    exp_miss = (pos < 0);
    if (exp_miss) begin
      if (!pt.exists(vpn)) begin
        rnd = $urandom();
        pt[vpn] = ($urandom_range(0, 5) == 0) ? 32'h0 : (rnd | 32'h1);
      end
      pte = pt[vpn];
      m_misses++;
    end else begin
      pte = m_pte[s][pos];
      m_hits++;
    end
    if (pte[0]) begin
      f = acc ? !pte[2] : !pte[1];
      exp_v = {f ? 32'h0 : {pte[31:12], va[11:0]}, 1'b1, f};
    end else begin
      exp_v = {32'h0, 1'b0, 1'b1};
    end
    exp_q.push_back(exp_v);
    if (!exp_miss) begin
      m_front(s, pos, vpn, pte);
    end else if (pte[0]) begin
      if (m_cnt[s] < TB_WAYS) begin
        pos = m_cnt[s];
        m_cnt[s]++;
      end else begin
        pos = TB_WAYS - 1;
      end
      m_front(s, pos, vpn, pte);
    end

    check("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;
    bus.vaddr_i = va;
    bus.access_type_i = acc;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.vaddr_i = $urandom();
    bus.access_type_i = ~acc;
    lat = 1;
    ptw_seen = 0;
    pte_sent = 1'b0;
    extra = 0;
    while (!bus.resp_valid_o && lat < 300) begin
      bus.ptw_req_ready_i = 1'b0;
      bus.ptw_resp_valid_i = 1'b0;
      bus.ptw_pte_i = $urandom();
      bus.req_valid_i = 1'($urandom_range(0, 1));
      if (bus.ptw_req_valid_o) begin
        check("ptw_vaddr", bus.ptw_vaddr_o, va);
        if ($urandom_range(0, 1) == 1) begin
          bus.ptw_req_ready_i = 1'b1;
          ptw_seen++;
        end
      end else if (bus.ptw_resp_ready_o && !pte_sent && $urandom_range(0, 2) != 0) begin
        bus.ptw_resp_valid_i = 1'b1;
        bus.ptw_pte_i = pte;
        pte_sent = 1'b1;
        extra = $urandom_range(0, 1);
      end
      @(negedge clk);
      lat++;
    end
    bus.req_valid_i = 1'b0;
    bus.ptw_req_ready_i = 1'b0;
    bus.ptw_resp_valid_i = (extra > 0);
    bus.ptw_pte_i = $urandom() | 32'h1;
    exp_v = exp_q.pop_front();
    if (lat >= 300) begin
      timeout_fail("resp_timeout");
    end else begin
      check("ptw_requests", 32'(ptw_seen), exp_miss ? 32'd1 : 32'd0);
      if (!exp_miss) check("hit_latency", 32'(lat), 32'd2);
      got = {bus.paddr_o, bus.hit_o, bus.fault_o};
      check("paddr", got[33:2], exp_v[33:2]);
      check("hit", 32'(got[1]), 32'(exp_v[1]));
      check("fault", 32'(got[0]), 32'(exp_v[0]));
      check("ptw_resp_ready_in_resp", 32'(bus.ptw_resp_ready_o), 32'd0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.ptw_resp_valid_i = 1'b0;
        check("resp_hold_valid", 32'(bus.resp_valid_o), 32'd1);
        check("resp_hold_paddr", bus.paddr_o, exp_v[33:2]);
      end
      bus.resp_ready_i = 1'b1;
      @(negedge clk);
      bus.resp_ready_i = 1'b0;
      bus.ptw_resp_valid_i = 1'b0;
      check("resp_done", 32'(bus.resp_valid_o), 32'd0);
      check("req_ready_after", 32'(bus.req_ready_o), 32'd1);
    end
  endtask

  initial begin
    int n;
    logic [19:0] vpn;
    bus.req_valid_i = 1'b0;
    bus.vaddr_i = '0;
    bus.access_type_i = ACC_READ;
    bus.resp_ready_i = 1'b0;
    bus.ptw_req_ready_i = 1'b0;
    bus.ptw_resp_valid_i = 1'b0;
    bus.ptw_pte_i = '0;
    m_reset();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    check("rst_ptw_req_valid", 32'(bus.ptw_req_valid_o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    pt[20'h00000] = 32'h1000000F;
    pt[20'h00002] = 32'h12000003;
    pt[20'h00003] = 32'h00000000;
    pt[20'h00018] = 32'h1234500F;
    pt[20'h00028] = 32'h2234500F;
    pt[20'h00038] = 32'h3234500F;
    pt[20'h00048] = 32'h4234500F;
    pt[20'h00058] = 32'h5234500F;
    pt[20'h00077] = 32'h7700000B;

    // Miss then hit on the same page
    access(32'h00000000, ACC_READ);
    access(32'h00000123, ACC_READ);
    // Write to a read-only page faults but still installs
    access(32'h00002000, ACC_WRITE);
    access(32'h00002789, ACC_READ);
    // Invalid PTE is not cached
    access(32'h00003000, ACC_READ);
    access(32'h00003000, ACC_WRITE);

    // LRU replacement in set 8
    access(32'h00018000, ACC_READ);
    access(32'h00028000, ACC_READ);
    access(32'h00038000, ACC_READ);
    access(32'h00048000, ACC_READ);
    access(32'h00018004, ACC_READ);
    access(32'h00028008, ACC_WRITE);
    access(32'h0004800C, ACC_READ);
    access(32'h00058000, ACC_READ);
    access(32'h00018010, ACC_READ);
    access(32'h00028020, ACC_READ);
    access(32'h00048030, ACC_WRITE);
    access(32'h00038040, ACC_READ);

`ifdef TLB_PERF_CNT_EN
    check("hit_cnt_mid", hit_cnt, 32'(m_hits));
    check("miss_cnt_mid", miss_cnt, 32'(m_misses));
`endif

    // Reset while waiting on the walker aborts the request
    bus.req_valid_i = 1'b1;
    bus.vaddr_i = 32'h00077000;
    bus.access_type_i = ACC_READ;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    n = 0;
    while (!bus.ptw_req_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout_fail("abort_ptw_req");
    bus.ptw_req_ready_i = 1'b1;
    @(negedge clk);
    bus.ptw_req_ready_i = 1'b0;
    n = 0;
    while (!bus.ptw_resp_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout_fail("abort_ptw_wait");
    check("abort_state", 32'(dbg_state), 32'(ST_PTW_WAIT));
    bus.ptw_resp_valid_i = 1'b1;
    bus.ptw_pte_i = pt[20'h00077];
    #1 rst_n = 1'b0;
    #1;
    check("abort_req_ready", 32'(bus.req_ready_o), 32'd1);
    check("abort_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    check("abort_ptw_req_valid", 32'(bus.ptw_req_valid_o), 32'd0);
    check("abort_ptw_resp_ready", 32'(bus.ptw_resp_ready_o), 32'd0);
    check("abort_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    bus.ptw_resp_valid_i = 1'b0;
    rst_n = 1'b1;
    m_reset();
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", 32'(bus.resp_valid_o), 32'd0);
    end
    access(32'h00077123, ACC_READ);
    access(32'h00000456, ACC_READ);

    // Randomized traffic over two contended sets
    for (int k = 0; k < 80; k++) begin
      vpn = 20'(($urandom_range(0, 5) << 4) | (($urandom_range(0, 1) == 1) ? 5 : 1));
      access({vpn, 12'($urandom())}, 1'($urandom_range(0, 1)));
    end

`ifdef TLB_PERF_CNT_EN
    check("hit_cnt_end", hit_cnt, 32'(m_hits));
    check("miss_cnt_end", miss_cnt, 32'(m_misses));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tlb.md
Name: tlb

Overview:
- Set-associative translation lookaside buffer between the CPU load/store path and the page-table walker (PTW).
- Translates 32-bit virtual addresses (4 KiB pages) to 32-bit physical addresses and checks read/write permission.
- On a miss, requests a PTE from the PTW, refills an entry using LRU replacement, then answers the original request.

Parameters:
- NUM_SETS, 16, number of sets; index = VPN[log2(NUM_SETS)-1:0], power of two.
- NUM_WAYS, 4, associativity; power of two.

Ports:
- clk  in  1  clock; the single clock domain.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid_i  in  1  CPU request valid.
- req_ready_o  out  1  TLB can accept a request.
- vaddr_i  in  32  virtual address.
- access_type_i  in  1  0 = read, 1 = write.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  CPU accepts the response.
- paddr_o  out  32  physical address.
- hit_o  out  1  a valid translation was found or installed.
- fault_o  out  1  page fault.
- ptw_req_valid_o  out  1  walk request valid.
- ptw_req_ready_i  in  1  PTW accepts the walk.
- ptw_vaddr_o  out  32  address to walk.
- ptw_resp_valid_i  in  1  PTE valid.
- ptw_resp_ready_o  out  1  TLB accepts the PTE.
- ptw_pte_i  in  32  leaf PTE.

Behaviour:
- PTE format:
  - PPN = pte[31:12]
  - bit0 V, bit1 R, bit2 W, bit3 X (X is stored but unused)
  - A PTE of all zero is invalid.
- Entry contents: valid, tag = VPN[19:log2(NUM_SETS)], PPN, R, W.
- Per-set true-LRU state uses log2(NUM_WAYS)-bit age counters.
- Reset (asynchronous, rst_n=0):
  - All entry valid bits and LRU ages cleared; FSM goes to IDLE.
  - req_ready_o=1; all other outputs 0.
  - A reset during any state aborts the operation; no response is produced.
- FSM states: IDLE, LOOKUP, PTW_REQ, PTW_WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - When req_valid_i&&req_ready_o, latch vaddr_i and access_type_i, then go to LOOKUP.
  - req_ready_o is 0 in every other state. Requests presented while busy are ignored and not queued.
- LOOKUP:
  - Compare the tag in all ways of the indexed set.
  - Hit: promote the way to MRU and go to RESP.
  - Miss: go to PTW_REQ.
- PTW_REQ:
  - ptw_req_valid_o=1 with ptw_vaddr_o = latched vaddr, held stable until ptw_req_ready_i.
  - Then go to PTW_WAIT.
- PTW_WAIT:
  - ptw_resp_ready_o=1 only in this state.
  - On ptw_resp_valid_i, capture the PTE.
  - V=1: install into the first invalid way (lowest index), else the LRU way. Mark it MRU, then form the response as a hit.
  - V=0: do not install; response is hit=0, fault=1, paddr=0.
  - Extra cycles of ptw_resp_valid_i outside PTW_WAIT are ignored.
- Response for a hit or installed entry:
  - Fault when (read && !R) || (write && !W).
  - No fault: paddr_o = {PPN, vaddr[11:0]}, hit_o=1, fault_o=0.
  - Fault: paddr_o=0, hit_o=1, fault_o=1. LRU is still updated.
- RESP:
  - resp_valid_o=1; paddr_o, hit_o and fault_o held stable until resp_valid_o&&resp_ready_i.
  - Then go to IDLE.
- Latency from request accept to resp_valid_o:
  - Hit: 2 cycles.
  - Miss: 3 cycles plus PTW handshake time.
- Faulting translations are never cached as faults; permission is rechecked on every access.

Optional Feature:
- Macro: TLB_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both reset to 0 and saturating.
  - hit_cnt_o increments on each LOOKUP hit; miss_cnt_o on each LOOKUP miss.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package tlb_pkg holds:
  - PTE bit-position constants (PTE_V=0, PTE_R=1, PTE_W=2, PTE_X=3) and PPN/offset widths.
  - ACC_READ/ACC_WRITE encodings.
  - FSM state encoding.
- Natural sub-module: tlb_lru, one per-set true-LRU age tracker.
  - Inputs: touch way, touch enable, valid mask.
  - Output: victim way.

Test Plan:
- Reset -> req_ready_o=1, resp_valid_o=0, ptw_req_valid_o=0.
- Miss on vaddr 0x00000000, PTW returns 0x1000000F -> one PTW request with ptw_vaddr_o=0x00000000; response paddr=0x10000000, hit=1, fault=0. Repeat with 0x00000123 -> paddr 0x10000123, no PTW request.
- Write to 0x00002000 whose PTE is 0x12000003 -> paddr 0, hit=1, fault=1. A read of 0x00002789 returns 0x12000789, fault=0.
- PTW returns 0x00000000 for 0x00003000 -> hit=0, fault=1, paddr 0; a second access issues a new PTW request (not cached).
- Fill set 8 with VPNs 0x18, 0x28, 0x38, 0x48 (PTEs 0x1234500F..0x4234500F); touch 0x18, 0x28, 0x48; refill 0x58 -> 0x38 evicted. Accessing 0x38 triggers a PTW request; 0x18, 0x28 and 0x48 hit without PTW.
- Assert rst_n low during PTW_WAIT -> no response is produced; a later lookup of that VPN misses; req_ready_o=1 after release.
